// File: rtl/rtc_read_sequencer_pkg.sv
// Shared definitions for the RTC display-refresh read sequencer:
// register address map, register count, chip-select order, FSM states.
package rtc_read_sequencer_pkg;

    localparam int N_REGS = 9;

    // Chip-select / register index order
    localparam int CS_SEG_HORA   = 0;
    localparam int CS_MIN_HORA   = 1;
    localparam int CS_HORA_HORA  = 2;
    localparam int CS_DIA        = 3;
    localparam int CS_MES        = 4;
    localparam int CS_JAHR       = 5;
    localparam int CS_SEG_TIMER  = 6;
    localparam int CS_MIN_TIMER  = 7;
    localparam int CS_HORA_TIMER = 8;

    // RTC register addresses
    localparam logic [7:0] ADDR_SEG_HORA   = 8'h21;
    localparam logic [7:0] ADDR_MIN_HORA   = 8'h22;
    localparam logic [7:0] ADDR_HORA_HORA  = 8'h23;
    localparam logic [7:0] ADDR_DIA        = 8'h24;
    localparam logic [7:0] ADDR_MES        = 8'h25;
    localparam logic [7:0] ADDR_JAHR       = 8'h26;
    localparam logic [7:0] ADDR_SEG_TIMER  = 8'h41;
    localparam logic [7:0] ADDR_MIN_TIMER  = 8'h42;
    localparam logic [7:0] ADDR_HORA_TIMER = 8'h43;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_LATCH,
        ST_DONE
    } state_t;

    function automatic logic is_timer_reg(input logic [3:0] idx);
        return idx >= 4'(CS_SEG_TIMER);
    endfunction

endpackage

// File: rtl/rtc_addr_rom.sv
// Combinational register-index to RTC-address lookup.
// Ports: idx (register index 0..8), addr (RTC register address).
module rtc_addr_rom (
    input  logic [3:0] idx,
    output logic [7:0] addr
);
    import rtc_read_sequencer_pkg::*;

    always_comb begin
        addr = 8'h00;
        unique case (idx)
            4'(CS_SEG_HORA):   addr = ADDR_SEG_HORA;
            4'(CS_MIN_HORA):   addr = ADDR_MIN_HORA;
            4'(CS_HORA_HORA):  addr = ADDR_HORA_HORA;
            4'(CS_DIA):        addr = ADDR_DIA;
            4'(CS_MES):        addr = ADDR_MES;
            4'(CS_JAHR):       addr = ADDR_JAHR;
            4'(CS_SEG_TIMER):  addr = ADDR_SEG_TIMER;
            4'(CS_MIN_TIMER):  addr = ADDR_MIN_TIMER;
            4'(CS_HORA_TIMER): addr = ADDR_HORA_TIMER;
            default:           addr = 8'h00;
        endcase
    end

endmodule

// File: rtl/rtc_read_sequencer.sv
// Sweeps the RTC display registers: per register request, wait for ack
// (with timeout), then pulse its chip select so the data bus is latched.
// Ports: clk, reset (sync, active-low), start, timer_en, hold_vec,
//        rtc_rd_req, rtc_addr, rtc_rd_done, cs_vec, busy, sweep_done,
//        timeout_err.
module rtc_read_sequencer #(
    parameter int TIMEOUT_CYC = 255,
    parameter int N_REGS      = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       timer_en,
    input  logic [8:0] hold_vec,
    output logic       rtc_rd_req,
    output logic [7:0] rtc_addr,
    input  logic       rtc_rd_done,
    output logic [8:0] cs_vec,
    output logic       busy,
    output logic       sweep_done,
    output logic       timeout_err
);
    import rtc_read_sequencer_pkg::*;

    localparam logic [3:0] LAST_IDX = 4'(N_REGS - 1);
    localparam logic [7:0] TMO      = 8'(TIMEOUT_CYC);

    state_t     state;
    logic [3:0] idx;
    logic [7:0] cnt;
    logic [7:0] rom_addr;
    logic       skip;
    logic       last;

    rtc_addr_rom u_rom (
        .idx  (idx),
        .addr (rom_addr)
    );

    assign skip = hold_vec[idx] | (is_timer_reg(idx) & ~timer_en);
    assign last = (idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            idx         <= '0;
            cnt         <= '0;
            rtc_rd_req  <= 1'b0;
            rtc_addr    <= '0;
            cs_vec      <= '0;
            busy        <= 1'b0;
            sweep_done  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            // Single-cycle pulses default low
            rtc_rd_req <= 1'b0;
            cs_vec     <= '0;
            sweep_done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_SELECT;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end
                ST_SELECT: begin
                    if (skip) begin
                        if (last) begin
                            state      <= ST_DONE;
                            sweep_done <= 1'b1;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end else begin
                        state      <= ST_ISSUE;
                        rtc_rd_req <= 1'b1;
                        rtc_addr   <= rom_addr;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT_ACK;
                    cnt   <= '0;
                end
                ST_WAIT_ACK: begin
                    // Ack wins over a timeout in the same cycle
                    if (rtc_rd_done) begin
                        state  <= ST_LATCH;
                        cs_vec <= 9'b1 << idx;
                    end else if (cnt == TMO) begin
                        timeout_err <= 1'b1;
                        if (last) begin
                            state      <= ST_DONE;
                            sweep_done <= 1'b1;
                        end else begin
                            state <= ST_SELECT;
                            idx   <= idx + 4'd1;
                        end
                    end else if (cnt != 8'hFF) begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_LATCH: begin
                    if (last) begin
                        state      <= ST_DONE;
                        sweep_done <= 1'b1;
                    end else begin
                        state <= ST_SELECT;
                        idx   <= idx + 4'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_read_sequencer.sv
// Directed bench for rtc_read_sequencer: sweeps, skips, timeout, reset.
// Bus responder acks one cycle after each request unless told not to.
module tb_rtc_read_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic       timer_en;
    logic [8:0] hold_vec;
    logic       rtc_rd_req;
    logic [7:0] rtc_addr;
    logic       rtc_rd_done;
    logic [8:0] cs_vec;
    logic       busy;
    logic       sweep_done;
    logic       timeout_err;

    rtc_read_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .timer_en    (timer_en),
        .hold_vec    (hold_vec),
        .rtc_rd_req  (rtc_rd_req),
        .rtc_addr    (rtc_addr),
        .rtc_rd_done (rtc_rd_done),
        .cs_vec      (cs_vec),
        .busy        (busy),
        .sweep_done  (sweep_done),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Responder controls
    logic [7:0] no_ack_addr;
    logic       inject_done;
    logic       pend;

    initial begin
        rtc_rd_done = 1'b0;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            rtc_rd_done = 1'b0;
            if (pend || inject_done) rtc_rd_done = 1'b1;
            pend = 1'b0;
            if (rtc_rd_req && rtc_addr != no_ack_addr) pend = 1'b1;
        end
    end

    // Monitor
    logic [7:0] reqq[$];
    int cs_tot[9];
    int multi_hot = 0;
    int sd_tot = 0;

    initial begin
        foreach (cs_tot[i]) cs_tot[i] = 0;
        forever begin
            @(negedge clk);
            if (rtc_rd_req) reqq.push_back(rtc_addr);
            for (int i = 0; i < 9; i++) if (cs_vec[i]) cs_tot[i]++;
            if ($countones(cs_vec) > 1) multi_hot++;
            if (sweep_done) sd_tot++;
        end
    end

    logic [7:0] addr_map[9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25,
                                8'h26, 8'h41, 8'h42, 8'h43};

    int req_base;
    int sd_base;
    int cs_base[9];

    task automatic snap();
        req_base = reqq.size();
        sd_base  = sd_tot;
        foreach (cs_base[i]) cs_base[i] = cs_tot[i];
    endtask

    task automatic run_sweep(input int restart_at, input int bound,
                             output int lat);
        int n;
        n = 0;
        @(negedge clk);
        start = 1'b1;
        do begin
            @(posedge clk);
            #1;
            n++;
            start = (n == restart_at);
        end while (!sweep_done && n < bound);
        start = 1'b0;
        lat = n + 1;
        check("sweep_done_seen", 32'(sweep_done), 1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Compare recorded requests/chip selects with what the mask allows.
    // lat_tag/exp_lat: expected start-to-sweep_done latency in cycles.
    task automatic verify(input string tag, input logic [8:0] en_mask,
                          input logic [8:0] acked, input int lat,
                          input int exp_lat);
        logic [7:0] expq[$];
        for (int i = 0; i < 9; i++) if (en_mask[i]) expq.push_back(addr_map[i]);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_nreq"}, 32'(reqq.size() - req_base), 32'(expq.size()));
        for (int k = 0; k < expq.size(); k++) begin
            if (req_base + k < reqq.size())
                check($sformatf("%s_addr%0d", tag, k),
                      32'(reqq[req_base + k]), 32'(expq[k]));
        end
        for (int i = 0; i < 9; i++)
            check($sformatf("%s_cs%0d", tag, i),
                  32'(cs_tot[i] - cs_base[i]), 32'(acked[i]));
        check({tag, "_sweeps"}, 32'(sd_tot - sd_base), 1);
        check({tag, "_busy_end"}, 32'(busy), 0);
    endtask

    int lat;
    int n;

    initial begin
        reset = 1'b0;
        start = 1'b0;
        timer_en = 1'b1;
        hold_vec = '0;
        no_ack_addr = 8'h00;
        inject_done = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", 32'(rtc_rd_req), 0);
        check("rst_addr", 32'(rtc_addr), 0);
        check("rst_cs", 32'(cs_vec), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_sweep_done", 32'(sweep_done), 0);
        check("rst_tmo", 32'(timeout_err), 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rel_req", 32'(rtc_rd_req), 0);
        check("rel_cs", 32'(cs_vec), 0);

        // Full sweep, 1-cycle ack
        snap();
        run_sweep(0, 500, lat);
        verify("full", 9'h1FF, 9'h1FF, lat, 38);
        check("full_tmo", 32'(timeout_err), 0);

        // Timer registers excluded
        timer_en = 1'b0;
        snap();
        run_sweep(0, 500, lat);
        verify("notimer", 9'h03F, 9'h03F, lat, 29);
        timer_en = 1'b1;

        // Register 2 held
        hold_vec = 9'b000000100;
        snap();
        run_sweep(0, 500, lat);
        verify("hold2", 9'h1FB, 9'h1FB, lat, 35);
        hold_vec = '0;

        // Second start mid-sweep is dropped
        snap();
        run_sweep(10, 500, lat);
        repeat (60) @(posedge clk);
        #1;
        verify("restart", 9'h1FF, 9'h1FF, lat, 38);

        // No ack for 0x24 -> timeout, sweep carries on at 0x25
        no_ack_addr = 8'h24;
        snap();
        run_sweep(0, 2000, lat);
        verify("tmo", 9'h1FF, 9'h1F7, lat, 292);
        check("tmo_err", 32'(timeout_err), 1);
        no_ack_addr = 8'h00;

        // Sticky across a clean sweep
        snap();
        run_sweep(0, 500, lat);
        check("tmo_sticky", 32'(timeout_err), 1);

        // Reset while waiting for the 0x22 ack
        no_ack_addr = 8'h22;
        snap();
        @(negedge clk);
        start = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            n++;
        end while (!(rtc_rd_req && rtc_addr == 8'h22) && n < 100);
        check("mid_req22_seen", 32'(rtc_addr), 32'h22);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_req", 32'(rtc_rd_req), 0);
        check("mid_rst_addr", 32'(rtc_addr), 0);
        check("mid_rst_cs", 32'(cs_vec), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_tmo", 32'(timeout_err), 0);
        check("mid_rst_sweep_done", 32'(sweep_done), 0);
        @(negedge clk);
        reset = 1'b1;
        inject_done = 1'b1;
        @(negedge clk);
        inject_done = 1'b0;
        #1;
        check("mid_rel_req", 32'(rtc_rd_req), 0);
        check("mid_rel_cs", 32'(cs_vec), 0);
        repeat (6) @(posedge clk);
        #1;
        check("late_done_cs1", 32'(cs_tot[1] - cs_base[1]), 0);
        check("late_done_busy", 32'(busy), 0);
        check("late_done_sweeps", 32'(sd_tot - sd_base), 0);
        no_ack_addr = 8'h00;

        check("one_hot", 32'(multi_hot), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rtc_read_sequencer.md
RTC_READ_SEQUENCER -- requirements
Module: rtc_read_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255: maximum cycles to wait for rtc_rd_done per register.
REQ-002 Parameter N_REGS, default 9: number of display registers refreshed per sweep; fixed at 9.
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-low reset (0 = reset).
REQ-005 start  in  1  one-cycle refresh request (periodic tick from the 1 Hz divider).
REQ-006 timer_en  in  1  1 = include the three timer registers in the sweep.
REQ-007 hold_vec  in  9  per-register hold; bit i set = register i under user edit, skip it.
REQ-008 rtc_rd_req  out  1  read request to the RTC bus interface.
REQ-009 rtc_addr  out  8  RTC register address for the current request.
REQ-010 rtc_rd_done  in  1  one-cycle pulse: RTC data is valid on the shared data bus this cycle.
REQ-011 cs_vec  out  9  one-hot chip selects, order: seg_hora, min_hora, hora_hora, dia, mes, jahr, seg_timer, min_timer, hora_timer.
REQ-012 busy  out  1  sweep in progress.
REQ-013 sweep_done  out  1  one-cycle pulse at end of every sweep.
REQ-014 timeout_err  out  1  sticky; set on any read timeout.

Function
REQ-015 Address map, index 0..8: 0x21, 0x22, 0x23, 0x24, 0x25, 0x26, 0x41, 0x42, 0x43.
REQ-016 States: IDLE, SELECT, ISSUE, WAIT_ACK, LATCH, DONE.
REQ-017 IDLE: busy=0; when start=1, go to SELECT with idx=0; otherwise stay in IDLE.
REQ-018 SELECT: skip idx when hold_vec[idx]=1, or when idx>=6 and timer_en=0.
REQ-019 SELECT: a skipped idx increments by one per cycle; idx=8 when skipped goes to DONE; a non-skipped idx goes to ISSUE.
REQ-020 ISSUE: rtc_rd_req=1 for exactly one cycle, rtc_addr = map[idx]; go to WAIT_ACK with the timeout counter cleared.
REQ-021 WAIT_ACK: rtc_addr stays stable; rtc_rd_done=1 goes to LATCH.
REQ-022 WAIT_ACK: when the counter reaches TIMEOUT_CYC, set timeout_err, assert no chip select, and advance as in REQ-024.
REQ-023 LATCH: cs_vec = one-hot(idx) for exactly one cycle, the cycle after rtc_rd_done (data held on bus by the bus interface).
REQ-024 Advance after LATCH or timeout: idx=8 goes to DONE; otherwise idx+1 goes to SELECT.
REQ-025 DONE: sweep_done=1 for one cycle, then IDLE.
REQ-026 start while busy is ignored; it is not queued.
REQ-027 hold_vec is sampled only in SELECT; a hold rising during WAIT_ACK does not cancel the latch.
REQ-028 rtc_rd_done outside WAIT_ACK is ignored.
REQ-029 At most one cs_vec bit is high in any cycle; cs_vec=0 outside LATCH.
REQ-030 Sweep latency with all registers enabled and 1-cycle ack: 1 + 9x4 + 1 cycles from start to sweep_done.
REQ-031 Timeout counter is 8 bits wide and saturates.
REQ-032 timeout_err is cleared only by reset.

Reset
REQ-033 reset=0 at a rising edge, in any state including mid-handshake: state=IDLE, idx=0, counter=0, all outputs 0, timeout_err=0.
REQ-034 rtc_rd_req and cs_vec are 0 in the cycle following reset release.

Structure
REQ-035 Shared package holds the address constants, N_REGS, the state encoding, and the cs index order.
REQ-036 One sub-module, rtc_addr_rom: a combinational idx-to-address lookup.
REQ-037 All outputs come from registered state; no combinational path from rtc_rd_done to rtc_rd_req.

Verification
REQ-038 Full sweep: start, timer_en=1, hold_vec=0, ack 1 cycle after each request -> addresses 0x21..0x26, 0x41..0x43 in order; cs bits 0..8 each pulse once; sweep_done at cycle 38.
REQ-039 timer_en=0 -> only 6 requests (0x21..0x26); cs bits 6..8 never asserted; sweep_done issued.
REQ-040 hold_vec=9'b000000100 -> address 0x23 never requested; cs_vec[2] stays 0; the other 8 latch.
REQ-041 No ack for address 0x24 -> after 255 cycles timeout_err=1, cs_vec[3] stays 0, the sweep continues at 0x25.
REQ-042 reset=0 during WAIT_ACK for 0x22 -> next cycle IDLE with all outputs 0; a late rtc_rd_done produces no cs pulse.
REQ-043 start pulsed again mid-sweep -> ignored; exactly one sweep_done.
